// File: rtl/quadrature_stimulus_generator.sv
// Quadrature A/B and push-button stimulus source that mimics a physical
// rotary encoder, driven by one-cycle rotate/press command pulses.
module quadrature_stimulus_generator #(
   parameter int DWELL_CYCLES = 100000,
   parameter int COUNT_WIDTH  = 8,
   parameter int PRESS_DWELLS = 2
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic                   i_Start,
   input  logic                   i_Direction,
   input  logic [COUNT_WIDTH-1:0] i_Step_Count,
   input  logic                   i_Press,
   output logic                   o_Encoder_A,
   output logic                   o_Encoder_B,
   output logic                   o_Encoder_Change_Mode,
   output logic                   o_Busy,
   output logic                   o_Done,
   output logic [COUNT_WIDTH-1:0] o_Steps_Remaining
);

   localparam int DW = $clog2(DWELL_CYCLES + 1);
   localparam int PW = (PRESS_DWELLS > 1) ? $clog2(PRESS_DWELLS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [PW-1:0] PRESS_LAST = PW'(PRESS_DWELLS - 1);
   localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, ROTATE, PRESS_HOLD, PRESS_GAP, FINISH
   } state_t;

   state_t                 state_q, state_d;
   logic [DW-1:0]          dwell_q, dwell_d;
   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic [1:0]             phase_q, phase_d;
   logic                   dir_q, dir_d;
   logic [COUNT_WIDTH-1:0] steps_q, steps_d;
   logic                   a_q, a_d, b_q, b_d;
   logic                   cm_q, cm_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // (A,B) for a phase index; 1 = clockwise (A leads B)
   function automatic logic [1:0] phase_ab(input logic cw, input logic [1:0] ph);
      case (ph)
         2'd0:    phase_ab = cw ? 2'b10 : 2'b01;
         2'd1:    phase_ab = 2'b11;
         2'd2:    phase_ab = cw ? 2'b01 : 2'b10;
         default: phase_ab = 2'b00;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      pcnt_d  = pcnt_q;
      phase_d = phase_q;
      dir_d   = dir_q;
      steps_d = steps_q;
      a_d     = a_q;
      b_d     = b_q;
      cm_d    = cm_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (i_Start) begin
               dir_d   = i_Direction;
               steps_d = i_Step_Count;
               busy_d  = 1'b1;
               dwell_d = DWELL_LAST;
               phase_d = 2'd0;
               if (i_Step_Count == '0) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d    = ROTATE;
                  {a_d, b_d} = phase_ab(i_Direction, 2'd0);
               end
            end else if (i_Press) begin
               state_d = PRESS_HOLD;
               busy_d  = 1'b1;
               cm_d    = 1'b1;
               dwell_d = DWELL_LAST;
               pcnt_d  = PRESS_LAST;
            end
         end
         ROTATE: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - DW'(1);
            end else begin
               dwell_d    = DWELL_LAST;
               phase_d    = phase_q + 2'd1;
               {a_d, b_d} = phase_ab(dir_q, phase_q + 2'd1);
               // End of the 00 phase closes one detent
               if (phase_q == 2'd3) begin
                  if (steps_q != '0) steps_d = steps_q - ONE;
                  if (steps_q <= ONE) begin
                     state_d    = FINISH;
                     done_d     = 1'b1;
                     {a_d, b_d} = 2'b00;
                  end
               end
            end
         end
         PRESS_HOLD: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - DW'(1);
            end else begin
               dwell_d = DWELL_LAST;
               if (pcnt_q != '0) begin
                  pcnt_d = pcnt_q - PW'(1);
               end else begin
                  pcnt_d  = PRESS_LAST;
                  cm_d    = 1'b0;
                  state_d = PRESS_GAP;
               end
            end
         end
         PRESS_GAP: begin
            if (dwell_q != '0) begin
               dwell_d = dwell_q - DW'(1);
            end else begin
               dwell_d = DWELL_LAST;
               if (pcnt_q != '0) begin
                  pcnt_d = pcnt_q - PW'(1);
               end else begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= IDLE;
         dwell_q <= '0;
         pcnt_q  <= '0;
         phase_q <= '0;
         dir_q   <= 1'b0;
         steps_q <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         cm_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         pcnt_q  <= pcnt_d;
         phase_q <= phase_d;
         dir_q   <= dir_d;
         steps_q <= steps_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cm_q    <= cm_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_Encoder_A           = a_q;
   assign o_Encoder_B           = b_q;
   assign o_Encoder_Change_Mode = cm_q;
   assign o_Busy                = busy_q;
   assign o_Done                = done_q;
   assign o_Steps_Remaining     = steps_q;

endmodule

// File: tb/tb_quadrature_stimulus_generator.sv
// Bench for quadrature_stimulus_generator: timeline reference model,
// command vector table, reset abort, max count and random streams.
module tb_quadrature_stimulus_generator;

   localparam int D  = 4;
   localparam int CW = 8;
   localparam int P  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          dir = 1'b0;
   logic          press = 1'b0;
   logic [CW-1:0] cnt = '0;
   logic          a, b, cm, busy, done;
   logic [CW-1:0] rem;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int m_kind = 0;
   int m_n = 0;
   int m_dir = 0;
   int m_cnt = 0;
   logic prev_a = 1'b0;
   int done_seen = 0;
   int last_done = 0;

   typedef struct packed {
      logic          a;
      logic          b;
      logic          cm;
      logic          busy;
      logic          done;
      logic [CW-1:0] rem;
   } exp_t;

   typedef struct {
      logic s;
      logic p;
      logic d;
      int   c;
      int   re_at;
      int   done_off;
      int   dones;
   } vec_t;

   quadrature_stimulus_generator #(
      .DWELL_CYCLES(D),
      .COUNT_WIDTH (CW),
      .PRESS_DWELLS(P)
   ) dut (
      .i_Clk                (clk),
      .i_Reset              (rst_n),
      .i_Start              (start),
      .i_Direction          (dir),
      .i_Step_Count         (cnt),
      .i_Press              (press),
      .o_Encoder_A          (a),
      .o_Encoder_B          (b),
      .o_Encoder_Change_Mode(cm),
      .o_Busy               (busy),
      .o_Done               (done),
      .o_Steps_Remaining    (rem)
   );

   always #5 clk = ~clk;

   // Expected outputs at cycle t from the accepted command's timeline
   function automatic exp_t model(input int t);
      exp_t e;
      int off, tot, ph;
      e = '0;
      if (m_kind == 0) return e;
      off = t - m_n - 1;
      if (m_kind == 1) begin
         tot = 4 * m_cnt * D;
         if (off < 0 || off > tot) return e;
         e.busy = 1'b1;
         if (off == tot) begin
            e.done = 1'b1;
            return e;
         end
         ph = (off / D) % 4;
         e.rem = CW'(m_cnt - off / (4 * D));
         e.a = (m_dir != 0) ? (ph < 2) : (ph == 1 || ph == 2);
         e.b = (m_dir != 0) ? (ph == 1 || ph == 2) : (ph < 2);
      end else begin
         tot = 2 * P * D;
         if (off < 0 || off > tot) return e;
         e.busy = 1'b1;
         if (off == tot) e.done = 1'b1;
         else e.cm = (off < P * D);
      end
      return e;
   endfunction

   task automatic check_now();
      exp_t e, g;
      e = model(cyc);
      g = {a, b, cm, busy, done, rem};
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL outputs cyc=%0d got a%b b%b cm%b busy%b done%b rem%0d want a%b b%b cm%b busy%b done%b rem%0d",
                  cyc, g.a, g.b, g.cm, g.busy, g.done, g.rem,
                  e.a, e.b, e.cm, e.busy, e.done, e.rem);
      end
      if (a === 1'b1 && prev_a === 1'b0) begin
         n_chk++;
         if (b !== (m_dir == 0)) begin
            n_fail++;
            $display("FAIL a_rise_b cyc=%0d got b=%b want %b", cyc, b, (m_dir == 0));
         end
      end
      prev_a = a;
      if (done === 1'b1) begin
         done_seen++;
         last_done = cyc;
      end
   endtask

   task automatic step(input logic s, input logic p, input logic d, input logic [CW-1:0] c);
      exp_t e;
      @(negedge clk);
      cyc++;
      check_now();
      e = model(cyc);
      if ((s || p) && !e.busy) begin
         m_n = cyc;
         if (s) begin
            m_kind = 1;
            m_dir = int'(d);
            m_cnt = int'(c);
         end else begin
            m_kind = 2;
         end
      end
      start = s;
      press = p;
      dir = d;
      cnt = c;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), CW'($urandom));
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic abort_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({a, b, cm, busy, done, rem} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got a%b b%b cm%b busy%b done%b rem%0d want all 0",
                  a, b, cm, busy, done, rem);
      end
      m_kind = 0;
      prev_a = 1'b0;
      @(negedge clk);
      cyc++;
      check_now();
      @(negedge clk);
      cyc++;
      check_now();
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t vt[5];
      int d0, n0;
      vt[0] = '{1'b1, 1'b0, 1'b1, 2, -1, 33, 1};
      vt[1] = '{1'b1, 1'b0, 1'b0, 1, -1, 17, 1};
      vt[2] = '{1'b1, 1'b0, 1'b1, 0, -1, 1, 1};
      vt[3] = '{1'b0, 1'b1, 1'b0, 0, -1, 17, 1};
      vt[4] = '{1'b1, 1'b1, 1'b1, 1, 8, 17, 1};

      repeat (3) @(negedge clk);
      n_chk++;
      if ({a, b, cm, busy, done, rem} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got a%b b%b cm%b busy%b done%b rem%0d want all 0",
                  a, b, cm, busy, done, rem);
      end
      rst_n = 1'b1;
      idle(3);

      for (int v = 0; v < 5; v++) begin
         d0 = done_seen;
         step(vt[v].s, vt[v].p, vt[v].d, CW'(vt[v].c));
         n0 = cyc;
         for (int k = 1; k <= 40; k++) begin
            if (k == vt[v].re_at) step(1'b1, 1'b0, ~vt[v].d, CW'(3));
            else step(1'b0, 1'b0, 1'b0, '0);
         end
         expect_int($sformatf("vec%0d_dones", v), done_seen - d0, vt[v].dones);
         expect_int($sformatf("vec%0d_done_off", v), last_done - n0, vt[v].done_off);
      end

      d0 = done_seen;
      step(1'b1, 1'b0, 1'b1, CW'(3));
      idle(6);
      abort_reset();
      idle(40);
      expect_int("abort_no_done", done_seen - d0, 0);
      step(1'b1, 1'b0, 1'b1, CW'(1));
      n0 = cyc;
      idle(20);
      expect_int("post_reset_dones", done_seen - d0, 1);
      expect_int("post_reset_done_off", last_done - n0, 17);

      d0 = done_seen;
      step(1'b1, 1'b0, 1'b0, CW'(255));
      n0 = cyc;
      idle(4 * 255 * D + 3);
      expect_int("maxcnt_dones", done_seen - d0, 1);
      expect_int("maxcnt_done_off", last_done - n0, 4 * 255 * D + 1);

      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              1'($urandom), CW'($urandom_range(0, 3)));
      end
      idle(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/quadrature_stimulus_generator.md
Name: quadrature_stimulus_generator

Overview:
- Transmitter-side counterpart of the rotary encoder receive path.
- Generates debounced-speed quadrature A/B waveforms and push-button presses from command pulses, equivalent to a physical encoder.
- Used for on-board self-test and hardware-in-loop regression of the encoder-to-time-set chain.
- Lives in the 5 MHz domain; its outputs drive the encoder debounce inputs through a mux at top level.

Parameters:
DWELL_CYCLES, 100000, clock cycles each quadrature phase (and press hold/gap quantum) is held; 20 ms at 5 MHz; must be ≥ 1.
COUNT_WIDTH, 8, width of step count and remaining-steps counter.
PRESS_DWELLS, 2, number of dwells the button is held high, then held low, per press.

Ports:
i_Clk  input  1  system clock (5 MHz)
i_Reset  input  1  asynchronous active-low reset
i_Start  input  1  1-cycle pulse: begin rotation command
i_Direction  input  1  1 = clockwise (A leads B), 0 = counter-clockwise (B leads A); sampled on accepted i_Start
i_Step_Count  input  COUNT_WIDTH  number of detents; sampled on accepted i_Start
i_Press  input  1  1-cycle pulse: emit one button press
o_Encoder_A  output  1  quadrature A
o_Encoder_B  output  1  quadrature B
o_Encoder_Change_Mode  output  1  button, active high
o_Busy  output  1  command in progress
o_Done  output  1  1-cycle pulse at command completion
o_Steps_Remaining  output  COUNT_WIDTH  detents not yet completed

Behaviour:
- Reset: i_Reset low asynchronously forces IDLE; all outputs 0; dwell counter, phase index and latched direction/count cleared. Reset mid-command aborts it with no o_Done.
- States: IDLE, ROTATE, PRESS_HOLD, PRESS_GAP, FINISH.
- IDLE:
  - i_Start → latch direction and count, enter ROTATE (or FINISH if count = 0).
  - Else i_Press → PRESS_HOLD.
  - i_Start and i_Press in the same cycle: i_Start wins, the press is dropped.
- While o_Busy = 1, i_Start and i_Press are ignored; there is no queueing.
- o_Busy is registered: 1 from the cycle after acceptance through the cycle o_Done is high.
- ROTATE phase sequence per detent, with (A,B) set at the start of each dwell:
  - CW: 10, 11, 01, 00.
  - CCW: 01, 11, 10, 00.
  - Each phase is held exactly DWELL_CYCLES.
  - Receiver contract: at the A rising edge, B = 0 for CW and B = 1 for CCW.
- Timing, with acceptance at cycle N:
  - The first phase appears at N+1.
  - Phase k of detent j (j from 0) starts at N+1+(4j+k)·DWELL_CYCLES.
  - The next detent follows the final 00 phase with no gap.
- o_Steps_Remaining loads the count at N+1 and decrements at the end of each detent's 00 phase.
  - When it reaches 0 → FINISH.
- FINISH lasts one cycle:
  - o_Done = 1 and o_Busy = 1 in that cycle.
  - IDLE next cycle, o_Busy = 0.
  - A, B are already 00.
- Count = 0: FINISH occurs at N+1. No A/B edges; o_Busy high for 1 cycle.
- Press timing:
  - PRESS_HOLD drives Change_Mode = 1 for PRESS_DWELLS·DWELL_CYCLES, starting N+1.
  - PRESS_GAP drives 0 for the same duration, to guarantee debounce release.
  - Then FINISH. A/B stay 00 throughout.
- Counters:
  - Dwell counter width is $clog2(DWELL_CYCLES+1).
  - It reloads on every phase change; there is no free-running prescaler, so the dwell is exact from acceptance.
- All outputs are registered; no combinational path from inputs to outputs.
- Max count is 2^COUNT_WIDTH−1. No wrap: the decrement never goes below 0.

Test Plan:
- DWELL_CYCLES=4, reset released, pulse i_Start with Dir=1, Count=2 at cycle N → (A,B) = 10@N+1, 11@N+5, 01@N+9, 00@N+13, repeated from N+17; o_Done only at N+33; o_Busy N+1..N+33; Steps_Remaining 2→1@N+17→0@N+33.
- Same with Dir=0, Count=1 → (A,B) = 01, 11, 10, 00 at N+1, N+5, N+9, N+13; Done@N+17; at each A rising edge B = 1.
- Start with Count=0 → no A/B change; o_Busy and o_Done both high only at N+1.
- i_Press, PRESS_DWELLS=2 → Change_Mode high N+1..N+8, low N+9..N+16, Done@N+17; A/B stay 0.
- i_Start and i_Press same cycle, plus a second i_Start mid-rotation → only the first rotation executes; no press; one o_Done.
- Assert i_Reset low during the 11 phase of a 3-step command → all outputs 0 within the same cycle (async); no o_Done. After release, a new Start with Count=1 runs a clean 4-phase sequence.
